multi_cycle_cu: RTL and testbench

- Multi-cycle successor to the single-cycle control unit: a Moore-style FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles.
- Uses one shared memory port with a ready handshake.
- Instruction set and opcode encodings are unchanged; adds a memory timeout watchdog, illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the multi-cycle datapath (ALU, ALUOut register, register file, PC).

---
 rtl/multi_cycle_cu_if.sv | 22 ++
 rtl/multi_cycle_cu.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_cycle_cu.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_cu_if.sv
// Shared memory port between the control unit and the memory system.
// The control unit drives the request side; memory answers with memReady.
interface multi_cycle_cu_if;
  logic memRead;
  logic memWrite;
  logic memAddrSel;
  logic memReady;

  modport master (
    output memRead,
    output memWrite,
    output memAddrSel,
    input  memReady
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  memAddrSel,
    output memReady
  );
endinterface

// File: rtl/multi_cycle_cu.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with memory watchdog, illegal-opcode trap and retired-instruction counter.
module multi_cycle_cu #(
  parameter int OPCODE_W    = 4,
  parameter int FUNC_W      = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  multi_cycle_cu_if.master    mem,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [FUNC_W-1:0]   funcCtrl,
  output logic                irWrite,
  output logic                regWrite,
  output logic                selDM,
  output logic                regSel,
  output logic                imSel,
  output logic                selFunc,
  output logic                selCtrl,
  output logic                ldPC,
  output logic [1:0]          pcSrc,
  output logic                retire,
  output logic [CNT_W-1:0]    instret,
  output logic                illegalOp,
  output logic                memTimeout
);

  localparam int CW = (MEM_TIMEOUT < 3) ? 1 : $clog2(MEM_TIMEOUT);

  localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(16);
  localparam logic [FUNC_W-1:0] F_NOP = FUNC_W'(64);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DEC,
    S_ADDR,
    S_MRD,
    S_WBM,
    S_MWR,
    S_JMP,
    S_BRZ,
    S_EXR,
    S_EXI,
    S_WBA,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] fc;
    logic              rd;
    logic              wr;
    logic              asel;
    logic              rw;
    logic              dm;
    logic              rs;
    logic              im;
    logic              sf;
    logic              sc;
    logic [1:0]        ps;
    logic              ret;
  } ctl_t;

  state_t         r_state;
  ctl_t           r_ctl;
  logic [CW-1:0]  r_cnt;
  logic           r_rs;
  logic [CNT_W-1:0] r_instret;
  logic           r_ill;
  logic           r_mto;

  state_t         w_nxt;
  logic [CW-1:0]  w_cnt;
  logic           w_rs;
  logic           w_ill;
  logic           w_mto;
  logic           w_wait;
  logic           w_lim;
  logic           w_ret;
  logic           w_fetchDone;

  logic [3:0]     w_op;
  logic           w_hi0;
  logic           w_ldst;
  logic           w_jmp;
  logic           w_brz;
  logic           w_tc;
  logic           w_imm;

  // Moore outputs of a state; only EXI and WBA need extra context.
  function automatic ctl_t f_moore(
    input state_t     s,
    input logic [1:0] alu,
    input logic       rs
  );
    ctl_t c;
    c    = '0;
    c.fc = F_NOP;
    unique case (s)
      S_FETCH: c.rd = 1'b1;
      S_ADDR: begin
        c.sc = 1'b1;
        c.im = 1'b1;
        c.fc = F_ADD;
      end
      S_MRD: begin
        c.rd   = 1'b1;
        c.asel = 1'b1;
      end
      S_WBM: begin
        c.rw  = 1'b1;
        c.dm  = 1'b1;
        c.ret = 1'b1;
      end
      S_MWR: begin
        c.wr   = 1'b1;
        c.asel = 1'b1;
      end
      S_JMP: begin
        c.ps  = 2'd2;
        c.ret = 1'b1;
      end
      S_BRZ: begin
        c.sc  = 1'b1;
        c.fc  = F_SUB;
        c.ps  = 2'd1;
        c.ret = 1'b1;
      end
      S_EXR: c.sf = 1'b1;
      S_EXI: begin
        c.sc = 1'b1;
        c.im = 1'b1;
        unique case (alu)
          2'b00: c.fc = F_ADD;
          2'b01: c.fc = F_SUB;
          2'b10: c.fc = F_AND;
          default: c.fc = F_OR;
        endcase
      end
      S_WBA: begin
        c.rw  = 1'b1;
        c.rs  = rs;
        c.ret = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign w_op   = opcode[3:0];
  assign w_hi0  = ((opcode >> 4) == '0);
  assign w_ldst = w_hi0 & (w_op[3:1] == 3'b000);
  assign w_jmp  = w_hi0 & (w_op == 4'b0010);
  assign w_brz  = w_hi0 & (w_op == 4'b0100);
  assign w_tc   = w_hi0 & (w_op == 4'b1000);
  assign w_imm  = w_hi0 & (w_op[3:2] == 2'b11);

  assign w_wait = (r_state == S_FETCH) |
                  (r_state == S_MRD) |
                  (r_state == S_MWR);
  // Limit reached when this idle cycle would push the count to MEM_TIMEOUT.
  assign w_lim  = (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_nxt = r_state;
    w_rs  = r_rs;
    w_ill = 1'b0;
    w_mto = 1'b0;
    unique case (r_state)
      S_IDLE:  w_nxt = S_FETCH;
      S_FETCH: if (mem.memReady) w_nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          w_ldst: w_nxt = S_ADDR;
          w_jmp:  w_nxt = S_JMP;
          w_brz:  w_nxt = S_BRZ;
          w_tc:   w_nxt = S_EXR;
          w_imm:  w_nxt = S_EXI;
          default: begin
            w_nxt = S_TRAP;
            w_ill = 1'b1;
          end
        endcase
      end
      S_ADDR:  w_nxt = opcode[0] ? S_MWR : S_MRD;
      S_MRD:   if (mem.memReady) w_nxt = S_WBM;
      S_MWR:   if (mem.memReady) w_nxt = S_FETCH;
      S_EXR: begin
        w_nxt = S_WBA;
        w_rs  = 1'b1;
      end
      S_EXI: begin
        w_nxt = S_WBA;
        w_rs  = 1'b0;
      end
      S_WBM, S_JMP, S_BRZ, S_WBA: w_nxt = S_FETCH;
      default: ;
    endcase
    if (w_wait && !mem.memReady && w_lim) begin
      w_nxt = S_TRAP;
      w_mto = 1'b1;
    end
    w_cnt = (w_wait && !mem.memReady && !w_lim) ?
            r_cnt + CW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ctl     <= f_moore(S_IDLE, 2'b00, 1'b0);
      r_cnt     <= '0;
      r_rs      <= 1'b0;
      r_instret <= '0;
      r_ill     <= 1'b0;
      r_mto     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= f_moore(w_nxt, opcode[1:0], w_rs);
      r_cnt   <= w_cnt;
      r_rs    <= w_rs;
      if (w_ret) r_instret <= r_instret + CNT_W'(1);
      if (w_ill) r_ill <= 1'b1;
      if (w_mto) r_mto <= 1'b1;
    end
  end

  // Handshake- and flag-qualified outputs act within the current cycle.
  assign w_fetchDone = (r_state == S_FETCH) & mem.memReady;
  assign w_ret = r_ctl.ret | ((r_state == S_MWR) & mem.memReady);

  assign mem.memRead    = r_ctl.rd;
  assign mem.memWrite   = r_ctl.wr;
  assign mem.memAddrSel = r_ctl.asel;

  assign funcCtrl   = r_ctl.fc;
  assign irWrite    = w_fetchDone;
  assign regWrite   = r_ctl.rw;
  assign selDM      = r_ctl.dm;
  assign regSel     = r_ctl.rs;
  assign imSel      = r_ctl.im;
  assign selFunc    = r_ctl.sf;
  assign selCtrl    = r_ctl.sc;
  assign ldPC       = w_fetchDone |
                      (r_state == S_JMP) |
                      ((r_state == S_BRZ) & zero);
  assign pcSrc      = r_ctl.ps;
  assign retire     = w_ret;
  assign instret    = r_instret;
  assign illegalOp  = r_ill;
  assign memTimeout = r_mto;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: per-cycle vector table plus
// hand sequences for watchdog, trap, async reset and counter wrap.
module tb_multi_cycle_cu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic [7:0] funcCtrl;
  logic       irWrite, regWrite, selDM, regSel;
  logic       imSel, selFunc, selCtrl, ldPC;
  logic [1:0] pcSrc;
  logic       retire, illegalOp, memTimeout;
  logic [15:0] instret;

  multi_cycle_cu_if m ();

  multi_cycle_cu #(
    .OPCODE_W(4), .FUNC_W(8), .MEM_TIMEOUT(15), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .mem(m),
    .opcode(opcode), .zero(zero),
    .funcCtrl(funcCtrl), .irWrite(irWrite),
    .regWrite(regWrite), .selDM(selDM),
    .regSel(regSel), .imSel(imSel),
    .selFunc(selFunc), .selCtrl(selCtrl),
    .ldPC(ldPC), .pcSrc(pcSrc),
    .retire(retire), .instret(instret),
    .illegalOp(illegalOp), .memTimeout(memTimeout)
  );

  logic       rst2;
  logic [3:0] op2;
  logic       zero2;
  logic [7:0] fc2;
  logic       irw2, rgw2, sdm2, rsl2;
  logic       ims2, sfn2, sct2, lpc2;
  logic [1:0] pcs2;
  logic       ret2, ill2, mto2;
  logic [3:0] instret2;

  multi_cycle_cu_if m2 ();

  multi_cycle_cu #(
    .OPCODE_W(4), .FUNC_W(8), .MEM_TIMEOUT(15), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .mem(m2),
    .opcode(op2), .zero(zero2),
    .funcCtrl(fc2), .irWrite(irw2),
    .regWrite(rgw2), .selDM(sdm2),
    .regSel(rsl2), .imSel(ims2),
    .selFunc(sfn2), .selCtrl(sct2),
    .ldPC(lpc2), .pcSrc(pcs2),
    .retire(ret2), .instret(instret2),
    .illegalOp(ill2), .memTimeout(mto2)
  );

  localparam logic [15:0] IRW = 16'h8000;
  localparam logic [15:0] MRD = 16'h4000;
  localparam logic [15:0] MWR = 16'h2000;
  localparam logic [15:0] ASL = 16'h1000;
  localparam logic [15:0] RGW = 16'h0800;
  localparam logic [15:0] SDM = 16'h0400;
  localparam logic [15:0] RSL = 16'h0200;
  localparam logic [15:0] IMS = 16'h0100;
  localparam logic [15:0] SFN = 16'h0080;
  localparam logic [15:0] SCT = 16'h0040;
  localparam logic [15:0] LPC = 16'h0020;
  localparam logic [15:0] PCJ = 16'h0010;
  localparam logic [15:0] PCB = 16'h0008;
  localparam logic [15:0] RET = 16'h0004;
  localparam logic [15:0] ILL = 16'h0002;
  localparam logic [15:0] MTO = 16'h0001;
  localparam logic [15:0] FET = MRD | IRW | LPC;

  localparam logic [7:0] NOP = 8'h40;
  localparam logic [7:0] ADD = 8'h02;
  localparam logic [7:0] SUB = 8'h04;
  localparam logic [7:0] AND = 8'h08;
  localparam logic [7:0] ORR = 8'h10;

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [7:0]  fc;
    logic [15:0] ct;
    logic [15:0] n;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t v(
    input logic r, input logic [3:0] op,
    input logic z, input logic rdy,
    input logic [7:0] fc, input logic [15:0] ct,
    input logic [15:0] n
  );
    vec_t t;
    t.r = r; t.op = op; t.z = z; t.rdy = rdy;
    t.fc = fc; t.ct = ct; t.n = n;
    return t;
  endfunction

  function automatic logic [15:0] ctl_now();
    return {irWrite, m.memRead, m.memWrite,
            m.memAddrSel, regWrite, selDM, regSel,
            imSel, selFunc, selCtrl, ldPC, pcSrc,
            retire, illegalOp, memTimeout};
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic imm_rows(
    input logic [3:0] op, input logic [7:0] fc,
    input logic [15:0] n
  );
    tbl.push_back(v(1, op, 0, 1, NOP, FET, n));
    tbl.push_back(v(1, op, 0, 1, NOP, 16'h0, n));
    tbl.push_back(v(1, op, 0, 1, fc, IMS | SCT, n));
    tbl.push_back(v(1, op, 0, 1, NOP, RGW | RET, n));
  endtask

  initial begin
    rst = 1'b0; opcode = 4'h0; zero = 1'b0;
    m.memReady = 1'b1;
    rst2 = 1'b0; op2 = 4'h2; zero2 = 1'b0;
    m2.memReady = 1'b1;

    tbl.push_back(v(0, 4'h0, 0, 1, NOP, 16'h0, 0));
    tbl.push_back(v(1, 4'h0, 0, 1, NOP, 16'h0, 0));
    imm_rows(4'hC, ADD, 0);
    tbl.push_back(v(1, 4'h0, 0, 1, NOP, FET, 1));
    tbl.push_back(v(1, 4'h0, 0, 1, NOP, 16'h0, 1));
    tbl.push_back(v(1, 4'h0, 0, 1, ADD, IMS | SCT, 1));
    tbl.push_back(v(1, 4'h0, 0, 0, NOP, MRD | ASL, 1));
    tbl.push_back(v(1, 4'h0, 0, 0, NOP, MRD | ASL, 1));
    tbl.push_back(v(1, 4'h0, 0, 0, NOP, MRD | ASL, 1));
    tbl.push_back(v(1, 4'h0, 0, 1, NOP, MRD | ASL, 1));
    tbl.push_back(v(1, 4'h0, 0, 1, NOP, RGW | SDM | RET, 1));
    tbl.push_back(v(1, 4'h4, 0, 1, NOP, FET, 2));
    tbl.push_back(v(1, 4'h4, 0, 1, NOP, 16'h0, 2));
    tbl.push_back(v(1, 4'h4, 1, 1, SUB,
                    SCT | LPC | PCB | RET, 2));
    tbl.push_back(v(1, 4'h4, 1, 1, NOP, FET, 3));
    tbl.push_back(v(1, 4'h4, 1, 1, NOP, 16'h0, 3));
    tbl.push_back(v(1, 4'h4, 0, 1, SUB, SCT | PCB | RET, 3));
    tbl.push_back(v(1, 4'h8, 0, 1, NOP, FET, 4));
    tbl.push_back(v(1, 4'h8, 0, 1, NOP, 16'h0, 4));
    tbl.push_back(v(1, 4'h8, 0, 1, NOP, SFN, 4));
    tbl.push_back(v(1, 4'h8, 0, 1, NOP, RGW | RSL | RET, 4));
    imm_rows(4'hD, SUB, 5);
    imm_rows(4'hE, AND, 6);
    imm_rows(4'hF, ORR, 7);
    tbl.push_back(v(1, 4'h1, 0, 0, NOP, MRD, 8));
    tbl.push_back(v(1, 4'h1, 0, 1, NOP, FET, 8));
    tbl.push_back(v(1, 4'h1, 0, 1, NOP, 16'h0, 8));
    tbl.push_back(v(1, 4'h1, 0, 1, ADD, IMS | SCT, 8));
    tbl.push_back(v(1, 4'h1, 0, 0, NOP, MWR | ASL, 8));
    tbl.push_back(v(1, 4'h1, 0, 1, NOP, MWR | ASL | RET, 8));
    tbl.push_back(v(1, 4'h2, 0, 1, NOP, FET, 9));
    tbl.push_back(v(1, 4'h2, 0, 1, NOP, 16'h0, 9));
    tbl.push_back(v(1, 4'h2, 0, 1, NOP, LPC | PCJ | RET, 9));
    tbl.push_back(v(1, 4'h3, 0, 1, NOP, FET, 10));
    tbl.push_back(v(1, 4'h3, 0, 1, NOP, 16'h0, 10));
    tbl.push_back(v(1, 4'h3, 0, 1, NOP, ILL, 10));
    tbl.push_back(v(1, 4'h3, 1, 1, NOP, ILL, 10));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      opcode = tbl[i].op;
      zero = tbl[i].z;
      m.memReady = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d func", i),
          32'(funcCtrl), 32'(tbl[i].fc));
      chk($sformatf("row%0d ctl", i),
          32'(ctl_now()), 32'(tbl[i].ct));
      chk($sformatf("row%0d instret", i),
          32'(instret), 32'(tbl[i].n));
      @(negedge clk);
    end

    for (int i = 0; i < 20; i++) begin
      zero = 1'($urandom);
      m.memReady = 1'($urandom);
      opcode = 4'($urandom);
      #1;
      chk("trap_hold", {8'h0, funcCtrl, ctl_now()},
          {8'h0, NOP, ILL});
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("trap_clear", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m.memReady = 1'b0;
    @(negedge clk);
    #1;
    chk("refetch", 32'(ctl_now()), 32'(MRD));

    @(negedge clk);
    m.memReady = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("to_wait%0d", i),
          {30'h0, m.memRead, memTimeout}, 32'h2);
      @(negedge clk);
    end
    #1;
    chk("to_trap", {30'h0, m.memRead, memTimeout}, 32'h1);

    @(negedge clk);
    m.memReady = 1'b0;
    do_reset();
    repeat (14) @(negedge clk);
    m.memReady = 1'b1;
    opcode = 4'h2;
    #1;
    chk("late_ready_irw", 32'(irWrite), 32'h1);
    @(negedge clk);
    #1;
    chk("late_ready_dec", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    #1;
    chk("late_ready_jmp", 32'(ctl_now()),
        32'(LPC | PCJ | RET));

    @(negedge clk);
    opcode = 4'h1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    m.memReady = 1'b0;
    #1;
    chk("mwr_before", {instret, 15'h0, m.memWrite},
        {16'd1, 15'h0, 1'b1});
    #2;
    rst = 1'b0;
    #1;
    chk("mwr_async", {instret, 14'h0, m.memWrite, retire},
        32'h0);
    @(negedge clk);
    rst = 1'b1;

    #1;
    chk("wrap_reset", 32'(instret2), 32'h0);
    rst2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    repeat (45) @(negedge clk);
    #1;
    chk("wrap_15", 32'(instret2), 32'd15);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_0", 32'(instret2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
